// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, lane-select widths
// and the request-qualification helpers used at acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int BYTE_SEL_W = 2;
  localparam int HALF_SEL_W = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_RESP
  } lsu_state_e;

  typedef struct packed {
    logic       write;
    logic [2:0] funct3;
  } lsu_op_t;

  function automatic logic f3_unsupported(input logic write, input logic [2:0] f3);
    if (write) return (f3 > F3_W);
    return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [BYTE_SEL_W-1:0] lo);
    case (f3[1:0])
      2'd1:    return lo[0];
      2'd2:    return (lo != '0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// master = core + memory environment, slave = the LSU.
interface load_store_unit_if #(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 32
);
  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [2:0]            reqFunct3;
  logic [ADDRSIZE+1:0]   reqAddr;
  logic [WORDSIZE-1:0]   reqWdata;

  logic                  respValid;
  logic [WORDSIZE-1:0]   respData;
  logic                  respErr;

  logic                  memRead;
  logic                  memWrite;
  logic [ADDRSIZE-1:0]   memAddress;
  logic [WORDSIZE-1:0]   memWriteData;
  logic [WORDSIZE-1:0]   memReadData;

  modport master (
    output reqValid, reqWrite, reqFunct3, reqAddr, reqWdata, memReadData,
    input  reqReady, respValid, respData, respErr,
           memRead, memWrite, memAddress, memWriteData
  );

  modport slave (
    input  reqValid, reqWrite, reqFunct3, reqAddr, reqWdata, memReadData,
    output reqReady, respValid, respData, respErr,
           memRead, memWrite, memAddress, memWriteData
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction (sign/zero extend) and sub-word store merge
// into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic [2:0]            funct3,
  input  logic [BYTE_SEL_W-1:0] addr_lo,
  input  logic [WORDSIZE-1:0]   rdata,
  input  logic [WORDSIZE-1:0]   wdata,
  output logic [WORDSIZE-1:0]   load_data,
  output logic [WORDSIZE-1:0]   merge_data
);
  localparam int NUM_LANES = WORDSIZE / 8;

  logic [NUM_LANES-1:0][7:0] rd_lanes, st_lanes, mg_lanes;
  logic [NUM_LANES-1:0]      lane_we;
  logic [HALF_SEL_W-1:0]     half_sel;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;

  assign rd_lanes = rdata;
  assign half_sel = addr_lo[BYTE_SEL_W-1 -: HALF_SEL_W];
  assign ld_byte  = rd_lanes[addr_lo];
  assign ld_half  = {rd_lanes[{half_sel, 1'b1}], rd_lanes[{half_sel, 1'b0}]};

  // Store data is replicated across lanes; lane_we picks which lanes replace the old word.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i]  = (funct3[1:0] == 2'd0) ? (addr_lo == BYTE_SEL_W'(i)) :
                         (funct3[1:0] == 2'd1) ? (half_sel == HALF_SEL_W'(i / 2)) : 1'b1;
    assign st_lanes[i] = (funct3[1:0] == 2'd0) ? wdata[7:0] :
                         (funct3[1:0] == 2'd1) ? wdata[8*(i%2) +: 8] : wdata[8*i +: 8];
    assign mg_lanes[i] = lane_we[i] ? st_lanes[i] : rd_lanes[i];
  end

  assign merge_data = mg_lanes;

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{(WORDSIZE-8){ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {{(WORDSIZE-8){1'b0}}, ld_byte};
      F3_H:    load_data = {{(WORDSIZE-16){ld_half[15]}}, ld_half};
      F3_HU:   load_data = {{(WORDSIZE-16){1'b0}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: RISC-V byte/half/word access with read-modify-write
// sub-word stores. Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);
  lsu_state_e          state_q, state_d;
  lsu_op_t             op_q, op_d;
  logic [ADDRSIZE+1:0] addr_q, addr_d;
  logic [WORDSIZE-1:0] wr_data_q, wr_data_d;
  logic [WORDSIZE-1:0] resp_data_q, resp_data_d;
  logic                err_q, err_d;
  logic                req_err;
  logic [WORDSIZE-1:0] load_data, merge_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = f3_unsupported(bus.reqWrite, bus.reqFunct3) ||
                   misaligned(bus.reqFunct3, bus.reqAddr[1:0]);
`else
  assign req_err = f3_unsupported(bus.reqWrite, bus.reqFunct3);
`endif

  // wr_data_q holds the raw store data until RD_WAIT replaces it with the merged word.
  lsu_align #(.WORDSIZE(WORDSIZE)) u_align (
    .funct3     (op_q.funct3),
    .addr_lo    (addr_q[1:0]),
    .rdata      (bus.memReadData),
    .wdata      (wr_data_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.reqValid) begin
          op_d        = '{write: bus.reqWrite, funct3: bus.reqFunct3};
          addr_d      = bus.reqAddr;
          wr_data_d   = bus.reqWdata;
          resp_data_d = '0;
          err_d       = req_err;
          if (req_err)                                   state_d = S_RESP;
          else if (bus.reqWrite && bus.reqFunct3 == F3_W) state_d = S_WR_ISSUE;
          else                                           state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (op_q.write) begin
          wr_data_d = merge_data;
          state_d   = S_WR_ISSUE;
        end else begin
          resp_data_d = load_data;
          state_d     = S_RESP;
        end
      end
      S_WR_ISSUE: state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them asynchronously.
  assign bus.reqReady     = (state_q == S_IDLE);
  assign bus.respValid    = (state_q == S_RESP);
  assign bus.respErr      = (state_q == S_RESP) && err_q;
  assign bus.respData     = (state_q == S_RESP) ? resp_data_q : '0;
  assign bus.memRead      = (state_q == S_RD_ISSUE);
  assign bus.memWrite     = (state_q == S_WR_ISSUE);
  assign bus.memAddress   = addr_q[ADDRSIZE+1:2];
  assign bus.memWriteData = (state_q == S_WR_ISSUE) ? wr_data_q : '0;

endmodule
